d_cache_sa: RTL and testbench
=============================

// Module: d_cache_sa
// PURPOSE
//  Parametrised set-associative data cache between the pipelined CPU MEM stage and the word-wide memory port.
//  Write-through, no-write-allocate, multi-word lines refilled by a burst FSM, true LRU when WAYS=2.
//  Uncached accesses bypass the arrays. A global invalidate input supports cache flush.
// PARAMETERS
//  WAYS        2  associativity; legal values 1 (direct mapped) or 2
//  INDEX_BITS  6  sets = 2**INDEX_BITS
//  LINE_BITS   2  words per line = 2**LINE_BITS; addr fields tag=[31:2+LINE_BITS+INDEX_BITS], index, word=[1+LINE_BITS:2]
// PORTS
//  clk       in   1   clock, all state on rising edge
//  clrn      in   1   asynchronous active-low reset
//  p_a       in   32  cpu word address (bits 1:0 ignored)
//  p_dout    in   32  cpu store data
//  p_din     out  32  cpu load data
//  p_strobe  in   1   cpu access request; held with p_a/p_rw/p_dout stable until p_ready
//  p_rw      in   1   1=write, 0=read
//  uncached  in   1   access bypasses arrays; valid with p_strobe
//  inval     in   1   invalidate all lines
//  p_ready   out  1   one-cycle completion pulse to cpu
//  m_a       out  32  mem address
//  m_dout    in   32  mem read data
//  m_din     out  32  mem write data
//  m_strobe  out  1   mem request
//  m_rw      out  1   mem 1=write, 0=read
//  m_ready   in   1   mem word-transfer complete (one word per cycle with m_ready=1)
// BEHAVIOUR
//  State: IDLE, FILL. Reset: IDLE, all valid=0, LRU=0, fill counter=0; tag/data arrays not reset.
//  Reset-state outputs: p_ready=0, m_strobe=0, m_rw=0; m_a=p_a, m_din=p_dout, p_din=m_dout (pass-through).
//  Lookup (comb, IDLE): hit = p_strobe & ~uncached & valid[way][index] & tag match, any way; miss otherwise.
//  IDLE read hit: p_din = hit way word[p_a word field], p_ready=1 same cycle, m_strobe=0; LRU[index] <= other way.
//  IDLE write (cached or not): m_strobe=1, m_rw=1, m_a=p_a, m_din=p_dout, p_ready=m_ready;
//    on m_ready, if cached hit: hit-way word <= p_dout, LRU updated; write miss leaves arrays untouched.
//  IDLE uncached read: m_strobe=1, m_rw=0, m_a=p_a, p_din=m_dout, p_ready=m_ready; arrays/LRU untouched.
//  IDLE cached read miss: latch victim way = first invalid way (way0 preferred), else LRU way; cnt<=0; ->FILL.
//  FILL: m_strobe=1, m_rw=0, m_a={tag,index,cnt,2'b00}, p_ready=0. On m_ready: victim word[cnt] <= m_dout, cnt++.
//    On m_ready with cnt=2**LINE_BITS-1: victim tag<=tag, valid<=1, cnt wraps to 0, ->IDLE.
//    Next IDLE cycle the held request hits: read miss latency = 2**LINE_BITS mem handshakes + 1 cycle.
//  Stall cycles (m_ready=0) hold m_a/cnt unchanged. WAYS=1: victim always way0, LRU unused.
//  inval=1: all valid and LRU bits cleared next edge, any state; beats a simultaneous fill-complete valid
//    set (line stays invalid; held read re-misses). FILL continues to completion regardless.
//  p_strobe dropped during FILL is a protocol violation; fill still completes, no p_ready.
//  clrn low mid-FILL: immediate return to IDLE, memory burst abandoned, all lines invalid.
//  p_ready never asserts without p_strobe; at most one p_ready per request.
// TESTING
//  Reset, read 0x100 cached, m_ready each cycle -> m_a 0x100,0x104,0x108,0x10C then p_ready, p_din=mem[0x100].
//  Read 0x108 after that fill -> p_ready same cycle, m_strobe=0, p_din=mem[0x108].
//  WAYS=2: fill 0x100, 0x500, re-read 0x100, read 0x900 -> victim is 0x500's way; 0x100 still hits.
//  Write 0x104=0xDEADBEEF on hit, m_ready after 3 stalls -> p_ready on 4th cycle, later read 0x104 hits 0xDEADBEEF;
//    write miss 0x2000 -> memory write only, later read 0x2000 misses.
//  Uncached read 0x100 with cached line present -> m_strobe=1, p_din=m_dout=0x12345678, no array update.
//  inval pulse on final fill beat, and clrn low mid-FILL -> line invalid, re-read misses; IDLE, m_strobe=0.

Source files
------------

// File: rtl/d_cache_sa.sv
// d_cache_sa: write-through, no-write-allocate set-associative data cache.
// Sits between the CPU MEM stage and a word-wide memory port. Read misses
// refill a whole line with a word burst. Two-way sets keep a one-bit LRU
// pointer naming the way to replace next. Uncached accesses bypass the arrays.
module d_cache_sa #(
   parameter int WAYS       = 2,
   parameter int INDEX_BITS = 6,
   parameter int LINE_BITS  = 2
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic [31:0] p_a,
   input  logic [31:0] p_dout,
   output logic [31:0] p_din,
   input  logic        p_strobe,
   input  logic        p_rw,
   input  logic        uncached,
   input  logic        inval,
   output logic        p_ready,
   output logic [31:0] m_a,
   input  logic [31:0] m_dout,
   output logic [31:0] m_din,
   output logic        m_strobe,
   output logic        m_rw,
   input  logic        m_ready
);

   localparam int SETS     = 2 ** INDEX_BITS;
   localparam int WORDS    = 2 ** LINE_BITS;
   localparam int TAG_LSB  = 2 + LINE_BITS + INDEX_BITS;
   localparam int TAG_BITS = 32 - TAG_LSB;

   typedef enum logic {IDLE, FILL} state_t;

   state_t                r_state, w_next;
   logic [SETS-1:0]       r_valid [WAYS];
   logic [SETS-1:0]       r_lru;
   logic [TAG_BITS-1:0]   r_tag   [WAYS][SETS];
   logic [31:0]           r_data  [WAYS][SETS][WORDS];
   logic [LINE_BITS-1:0]  r_cnt;
   logic                  r_victim;
   logic [TAG_BITS-1:0]   r_fillTag;
   logic [INDEX_BITS-1:0] r_fillIdx;

   logic [TAG_BITS-1:0]   w_tag;
   logic [INDEX_BITS-1:0] w_idx;
   logic [LINE_BITS-1:0]  w_word;
   logic [WAYS-1:0]       w_wayHit;
   logic                  w_hit, w_hitWay, w_victim;
   logic                  w_readHit, w_writeHit, w_startFill, w_fillBeat, w_fillDone;
   logic                  w_unused;

   assign w_tag    = p_a[31:TAG_LSB];
   assign w_idx    = p_a[TAG_LSB-1:2+LINE_BITS];
   assign w_word   = p_a[1+LINE_BITS:2];
   assign w_unused = ^p_a[1:0];

   // Tag lookup in every way, lowest hitting way wins, and victim choice for a miss.
   always_comb begin
      w_wayHit = '0;
      w_hitWay = 1'b0;
      w_victim = r_lru[w_idx];
      for (int w = 0; w < WAYS; w++)
         w_wayHit[w] = r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag);
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (w_wayHit[w]) w_hitWay = 1'(w);
         if (!r_valid[w][w_idx]) w_victim = 1'(w);
      end
      if (WAYS == 1) w_victim = 1'b0;
      w_hit = p_strobe && !uncached && (|w_wayHit);
   end

   assign w_readHit   = (r_state == IDLE) && w_hit && !p_rw;
   assign w_writeHit  = (r_state == IDLE) && w_hit && p_rw && m_ready;
   assign w_startFill = (r_state == IDLE) && p_strobe && !p_rw && !uncached && !w_hit;
   assign w_fillBeat  = (r_state == FILL) && m_ready;
   assign w_fillDone  = w_fillBeat && (r_cnt == LINE_BITS'(WORDS - 1));

   // Next state and the CPU/memory handshake outputs; defaults pass addresses and data straight through.
   always_comb begin
      w_next   = r_state;
      p_ready  = 1'b0;
      m_strobe = 1'b0;
      m_rw     = 1'b0;
      m_a      = p_a;
      m_din    = p_dout;
      p_din    = m_dout;
      case (r_state)
         IDLE: begin
            if (p_strobe) begin
               if (p_rw) begin
                  m_strobe = 1'b1;
                  m_rw     = 1'b1;
                  p_ready  = m_ready;
               end else if (uncached) begin
                  m_strobe = 1'b1;
                  p_ready  = m_ready;
               end else if (w_hit) begin
                  p_din    = r_data[w_hitWay][w_idx][w_word];
                  p_ready  = 1'b1;
               end else begin
                  w_next   = FILL;
               end
            end
         end
         FILL: begin
            m_strobe = 1'b1;
            m_a      = {r_fillTag, r_fillIdx, r_cnt, 2'b00};
            if (w_fillDone) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // State, burst counter and the latched line/victim of the refill in progress.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_victim  <= 1'b0;
         r_fillTag <= '0;
         r_fillIdx <= '0;
      end else begin
         r_state <= w_next;
         if (w_startFill) begin
            r_cnt     <= '0;
            r_victim  <= w_victim;
            r_fillTag <= w_tag;
            r_fillIdx <= w_idx;
         end else if (w_fillBeat) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Valid and LRU bits; invalidate outranks a fill completing in the same cycle.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
         r_lru <= '0;
      end else if (inval) begin
         for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
         r_lru <= '0;
      end else begin
         if (w_fillDone) r_valid[r_victim][r_fillIdx] <= 1'b1;
         if ((WAYS > 1) && (w_readHit || w_writeHit)) r_lru[w_idx] <= ~w_hitWay;
      end
   end

   // Tag and data arrays carry no reset; they are only trusted behind a valid bit.
   always_ff @(posedge clk) begin
      if (w_writeHit) r_data[w_hitWay][w_idx][w_word] <= p_dout;
      if (w_fillBeat) r_data[r_victim][r_fillIdx][r_cnt] <= m_dout;
      if (w_fillDone) r_tag[r_victim][r_fillIdx] <= r_fillTag;
   end

endmodule

// File: tb/tb_d_cache_sa.sv
// tb_d_cache_sa: directed and randomized checks of d_cache_sa against a
// line-level cache model and a word-addressed memory model.
module tb_d_cache_sa;

   localparam int SETS  = 64;
   localparam int WORDS = 4;

   logic        clk = 1'b0;
   logic        clrn = 1'b0;
   logic [31:0] p_a = '0, p_dout = '0, p_din;
   logic        p_strobe = 1'b0, p_rw = 1'b0, uncached = 1'b0, inval = 1'b0;
   logic        p_ready;
   logic [31:0] m_a, m_din;
   logic [31:0] m_dout = '0;
   logic        m_strobe, m_rw;
   logic        m_ready = 1'b0;

   int checks = 0;
   int errors = 0;
   int readyPct = 100;
   int fixedStalls = -1;
   int lastReadyCyc = 0;

   logic [31:0] mem [int unsigned];

   bit          mValid [2][SETS];
   int          mTag   [2][SETS];
   logic [31:0] mData  [2][SETS][WORDS];
   int          mLru   [SETS];

   d_cache_sa dut (
      .clk(clk), .clrn(clrn), .p_a(p_a), .p_dout(p_dout), .p_din(p_din),
      .p_strobe(p_strobe), .p_rw(p_rw), .uncached(uncached), .inval(inval),
      .p_ready(p_ready), .m_a(m_a), .m_dout(m_dout), .m_din(m_din),
      .m_strobe(m_strobe), .m_rw(m_rw), .m_ready(m_ready)
   );

   always #5 clk = ~clk;

   // Counts one comparison and reports it when observed differs from expected.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] memRead(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'hA5A5_3C3C;
   endfunction

   function automatic int idxOf(input logic [31:0] a);
      return int'((a >> 4) & 32'h3F);
   endfunction

   function automatic int tagOf(input logic [31:0] a);
      return int'(a >> 10);
   endfunction

   function automatic int wordOf(input logic [31:0] a);
      return int'((a >> 2) & 32'h3);
   endfunction

   function automatic int modelFind(input logic [31:0] a);
      for (int w = 0; w < 2; w++)
         if (mValid[w][idxOf(a)] && mTag[w][idxOf(a)] == tagOf(a)) return w;
      return -1;
   endfunction

   function automatic void modelClear();
      for (int w = 0; w < 2; w++)
         for (int s = 0; s < SETS; s++) mValid[w][s] = 1'b0;
      for (int s = 0; s < SETS; s++) mLru[s] = 0;
   endfunction

   // One CPU request from strobe to p_ready, with optional inval on a fill beat or reset after N read beats.
   task automatic applyStimulus(input logic [31:0] addr, input bit rw, input bit unc,
                                input logic [31:0] data, input int invalBeat, input int resetBeat);
      int way, rdCount, wrCount, readyCyc, expReads, idx;
      bit done, isHit;
      logic [31:0] expAddr, obsDin, expDin;
      way = modelFind(addr);
      idx = idxOf(addr);
      isHit = !rw && !unc && (way >= 0);
      expReads = rw ? 0 : (unc ? 1 : (isHit ? 0 : (invalBeat > 0 ? 8 : 4)));
      rdCount = 0; wrCount = 0; readyCyc = 0; done = 0; obsDin = '0;
      for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            p_strobe = 1'b1; p_a = addr; p_rw = rw; uncached = unc; p_dout = data;
         end
         m_ready = (fixedStalls >= 0) ? (cyc > fixedStalls) : ($urandom_range(99) < readyPct);
         inval = 1'b0;
         if (invalBeat > 0 && rdCount == invalBeat - 1) begin
            m_ready = 1'b1;
            inval = 1'b1;
         end
         #1 m_dout = memRead(m_a);
         #1;
         if (resetBeat > 0 && rdCount == resetBeat) begin
            clrn = 1'b0;
            #1;
            checkOutput("rst_mid_mstrobe", {31'b0, m_strobe}, 32'd0);
            checkOutput("rst_mid_pready", {31'b0, p_ready}, 32'd0);
            checkOutput("rst_mid_ma", m_a, addr);
            p_strobe = 1'b0;
            m_ready = 1'b0;
            @(negedge clk);
            clrn = 1'b1;
            modelClear();
            return;
         end
         if (m_strobe && m_ready) begin
            if (m_rw) begin
               wrCount++;
               checkOutput("wr_addr", m_a, addr);
               checkOutput("wr_data", m_din, data);
               mem[m_a] = m_din;
            end else begin
               expAddr = unc ? addr : ((addr & ~32'hF) + 32'(4 * (rdCount % WORDS)));
               checkOutput("rd_addr", m_a, expAddr);
               rdCount++;
            end
         end
         if (p_ready) begin
            done = 1;
            readyCyc = cyc;
            obsDin = p_din;
            if (isHit) checkOutput("hit_mstrobe", {31'b0, m_strobe}, 32'd0);
         end
      end
      inval = 1'b0;
      lastReadyCyc = readyCyc;
      if (!done) begin
         checkOutput("timeout", 32'd0, 32'd1);
         p_strobe = 1'b0;
         return;
      end
      if (rw) begin
         checkOutput("wr_beats", wrCount, 32'd1);
         checkOutput("wr_reads", rdCount, 32'd0);
         if (!unc && way >= 0) begin
            mData[way][idx][wordOf(addr)] = data;
            mLru[idx] = 1 - way;
         end
      end else begin
         checkOutput("rd_beats", rdCount, expReads);
         if (unc) begin
            expDin = memRead(addr);
         end else if (isHit) begin
            expDin = mData[way][idx][wordOf(addr)];
            checkOutput("hit_latency", readyCyc, 32'd1);
            mLru[idx] = 1 - way;
         end else begin
            if (invalBeat > 0) modelClear();
            way = !mValid[0][idx] ? 0 : (!mValid[1][idx] ? 1 : mLru[idx]);
            mValid[way][idx] = 1'b1;
            mTag[way][idx] = tagOf(addr);
            for (int k = 0; k < WORDS; k++)
               mData[way][idx][k] = memRead((addr & ~32'hF) + 32'(4 * k));
            mLru[idx] = 1 - way;
            expDin = memRead(addr);
         end
         checkOutput("p_din", obsDin, expDin);
      end
      @(negedge clk);
      p_strobe = 1'b0;
      m_ready = ($urandom_range(99) < 50);
      #2;
      checkOutput("idle_pready", {31'b0, p_ready}, 32'd0);
      checkOutput("idle_mstrobe", {31'b0, m_strobe}, 32'd0);
   endtask

   // Pulses inval for one idle cycle.
   task automatic pulseInval();
      @(negedge clk);
      p_strobe = 1'b0;
      inval = 1'b1;
      @(negedge clk);
      inval = 1'b0;
      modelClear();
   endtask

   initial begin
      logic [31:0] addr;
      modelClear();
      p_a = 32'h0000_1234; p_dout = 32'hCAFE_F00D; m_dout = 32'h0000_55AA;
      #3;
      checkOutput("rst_pready", {31'b0, p_ready}, 32'd0);
      checkOutput("rst_mstrobe", {31'b0, m_strobe}, 32'd0);
      checkOutput("rst_mrw", {31'b0, m_rw}, 32'd0);
      checkOutput("rst_ma", m_a, 32'h0000_1234);
      checkOutput("rst_mdin", m_din, 32'hCAFE_F00D);
      checkOutput("rst_pdin", p_din, 32'h0000_55AA);
      @(negedge clk);
      clrn = 1'b1;

      readyPct = 100;
      applyStimulus(32'h100, 0, 0, 0, 0, 0);
      applyStimulus(32'h108, 0, 0, 0, 0, 0);
      applyStimulus(32'h500, 0, 0, 0, 0, 0);
      applyStimulus(32'h100, 0, 0, 0, 0, 0);
      applyStimulus(32'h900, 0, 0, 0, 0, 0);
      applyStimulus(32'h100, 0, 0, 0, 0, 0);
      applyStimulus(32'h500, 0, 0, 0, 0, 0);
      applyStimulus(32'h100, 0, 0, 0, 0, 0);

      fixedStalls = 3;
      applyStimulus(32'h104, 1, 0, 32'hDEAD_BEEF, 0, 0);
      checkOutput("wr_stall_cycle", lastReadyCyc, 32'd4);
      fixedStalls = -1;
      applyStimulus(32'h104, 0, 0, 0, 0, 0);
      applyStimulus(32'h2000, 1, 0, 32'h0BAD_F00D, 0, 0);
      applyStimulus(32'h2000, 0, 0, 0, 0, 0);

      mem[32'h100] = 32'h1234_5678;
      applyStimulus(32'h100, 0, 1, 0, 0, 0);
      applyStimulus(32'h100, 0, 0, 0, 0, 0);

      applyStimulus(32'h3000, 0, 0, 0, 4, 0);
      applyStimulus(32'h3000, 0, 0, 0, 0, 0);
      applyStimulus(32'h4000, 0, 0, 0, 0, 2);
      applyStimulus(32'h4000, 0, 0, 0, 0, 0);
      applyStimulus(32'h100, 0, 0, 0, 0, 0);
      applyStimulus(32'h100, 0, 0, 0, 0, 0);
      pulseInval();
      applyStimulus(32'h100, 0, 0, 0, 0, 0);

      readyPct = 70;
      for (int n = 0; n < 200; n++) begin
         addr = ($urandom_range(3) << 10) | (($urandom_range(3) + 16) << 4) | ($urandom_range(3) << 2);
         if ($urandom_range(99) < 5)
            mem[($urandom_range(3) << 10) | (($urandom_range(3) + 16) << 4) | ($urandom_range(3) << 2)] = $urandom;
         if ($urandom_range(99) < 4) pulseInval();
         applyStimulus(addr, $urandom_range(99) < 30, $urandom_range(99) < 15, $urandom, 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
